// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART feeder, transmitter and receiver.
//   UART_DATA_W     default byte width
//   feeder_state_t  sender FSM state encoding used by uart_tx_feeder
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Start/busy handshake between the feeder (master) and the UART transmitter
// (slave).
//   tx_data   master -> slave  byte presented to the transmitter
//   tx_start  master -> slave  one-cycle start request
//   tx_busy   slave  -> master transmitter busy for the duration of a frame
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;

    modport master (output tx_data, output tx_start, input  tx_busy);
    modport slave  (input  tx_data, input  tx_start, output tx_busy);

endinterface : uart_tx_feeder_if

// File: rtl/uart_tx_feeder_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Turns the raw, asynchronous push-button into a single-cycle push pulse on
// each accepted press (rising edge of the cleaned level). Release yields
// nothing.
// Build option: UART_FEEDER_DEBOUNCE_EN
//   defined   : 2-FF sync -> debounce counter -> registered edge detect
//   undefined : 2-FF sync -> registered edge detect (DEBOUNCE_CYCLES unused)
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   btn_in      raw button level
//   push        one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic push
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       push_q, push_d;
    logic       edge_src;

    // Guard against a nonsensical configuration; elaborates to nothing.
    if (DEBOUNCE_CYCLES < 1) begin : g_invalid_debounce_cycles
    end

    assign sync_d = {sync_q[0], btn_in};

`ifdef UART_FEEDER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement (a bounce back) restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign edge_src = level_q;
`else
    assign edge_src = sync_q[1];
`endif

    assign prev_d = edge_src;
    assign push_d = edge_src & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            push_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            push_q <= push_d;
        end
    end

    assign push = push_q;

endmodule : btn_debounce

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Queues the switch byte on every debounced button press and feeds the queue
// to the UART transmitter one byte at a time over a start/busy handshake.
// Build option: UART_FEEDER_DEBOUNCE_EN (see btn_debounce).
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   btn_in       raw push-button
//   sw_data      switch byte, captured in the push cycle
//   tx_if        master side of the transmitter handshake
//   fifo_count   current FIFO occupancy
//   full, empty  occupancy flags
//   overflow     sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W          = UART_DATA_W,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_in,
    input  logic [DATA_W-1:0]        sw_data,
    uart_tx_feeder_if.master         tx_if,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic push;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .push   (push)
    );

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop, do_push;

    feeder_state_t     state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign pop = (state_q == ST_IDLE) && !empty && !tx_if.tx_busy;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(pop);
        overflow_d = overflow_q | (push && !do_push);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= sw_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------------------------------------------------- sender FSM
    // tx_start is registered: it is asserted on the IDLE->START transition so
    // that it is high exactly while the FSM sits in START.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timer_d    = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_data_d  = fifo_mem[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_if.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte as sent.
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_if.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
        end
    end

    assign tx_if.tx_start = tx_start_q;
    assign tx_if.tx_data  = tx_data_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Scoreboard bench for uart_tx_feeder: every press that should reach the line
// pushes its byte to a queue; every tx_start pops and compares it.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int DEB_CYC     = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int HOLD        = 12;
`ifdef UART_FEEDER_DEBOUNCE_EN
    localparam int PUSH_LAT = 2 + DEB_CYC + 1;
`else
    localparam int PUSH_LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              btn_in = 1'b0;
    logic [DATA_W-1:0] sw_data = '0;
    logic [2:0]        fifo_count;
    logic              full, empty, overflow;

    logic busy_force = 1'b0;
    logic model_en   = 1'b1;
    int   frame_len  = 10;
    int   busy_cnt   = 0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_count = 0;
    int last_start_cyc = 0;
    int prev_start_cyc = 0;
    logic prev_start = 1'b0;
    logic [DATA_W-1:0] sb[$];

    uart_tx_feeder_if #(.DATA_W(DATA_W)) tx_if ();

    assign tx_if.tx_busy = busy_force | (model_en && busy_cnt != 0);

    uart_tx_feeder #(
        .DATA_W          (DATA_W),
        .DEPTH           (DEPTH),
        .DEBOUNCE_CYCLES (DEB_CYC),
        .ACK_TIMEOUT     (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .sw_data    (sw_data),
        .tx_if      (tx_if),
        .fifo_count (fifo_count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple transmitter model: busy for frame_len cycles after a start.
    always @(posedge clk) begin
        if (tx_if.tx_start && model_en) busy_cnt <= frame_len;
        else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every start request is scored against the queue.
    always @(negedge clk) begin
        if (tx_if.tx_start) begin
            logic [DATA_W-1:0] exp_b;
            if (prev_start) check_eq("start_consecutive", 1, 0);
            if (sb.size() == 0) begin
                check_eq("unexpected_start", 1, 0);
            end else begin
                exp_b = sb.pop_front();
                check_eq("tx_data", tx_if.tx_data, exp_b);
                $display("tx byte %02h at cycle %0d", tx_if.tx_data, cyc);
            end
            start_count++;
            prev_start_cyc = last_start_cyc;
            last_start_cyc = cyc;
        end
        prev_start = tx_if.tx_start;
    end

    task automatic press(input logic [DATA_W-1:0] val, input bit expect_sent);
        @(negedge clk);
        sw_data = val;
        btn_in  = 1'b1;
        if (expect_sent) sb.push_back(val);
        repeat (HOLD) @(negedge clk);
        btn_in = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        repeat (frame_len + 25) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx_start"}, tx_if.tx_start, 0);
        check_eq({tag, "_tx_data"},  tx_if.tx_data, 0);
        check_eq({tag, "_count"},    fifo_count, 0);
        check_eq({tag, "_empty"},    empty, 1);
        check_eq({tag, "_full"},     full, 0);
        check_eq({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, first_cyc, st_cyc;
        bit seen;

        // ---- reset state
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---- clean press, idle transmitter: start 2 cycles after push
        @(negedge clk);
        sw_data = 8'hB5;
        btn_in  = 1'b1;
        sb.push_back(8'hB5);
        first_cyc = -1; st_cyc = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (first_cyc < 0 && fifo_count != 0) first_cyc = cyc;
            if (tx_if.tx_start) begin
                seen = 1;
                st_cyc = cyc;
                check_eq("count_at_start", fifo_count, 0);
            end
        end
        check_eq("clean_start_seen", seen, 1);
        check_eq("push_to_start_latency", st_cyc - first_cyc, 1);
        repeat (HOLD) @(negedge clk);
        btn_in = 1'b0;
        repeat (HOLD) @(negedge clk);
        wait_drain(100);
        check_eq("clean_count_final", fifo_count, 0);

        // ---- bouncing press and release: exactly one byte
        base = start_count;
`ifdef UART_FEEDER_DEBOUNCE_EN
        @(negedge clk);
        sw_data = 8'h3C;
        sb.push_back(8'h3C);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1; repeat (2) @(negedge clk);
            btn_in = 1'b0; repeat (2) @(negedge clk);
        end
        btn_in = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b0; repeat (2) @(negedge clk);
            btn_in = 1'b1; repeat (2) @(negedge clk);
        end
        btn_in = 1'b0;
        repeat (30) @(negedge clk);
`else
        press(8'h3C, 1);
        repeat (20) @(negedge clk);
`endif
        check_eq("bounce_start_count", start_count - base, 1);
        wait_drain(100);

        // ---- fill while busy, overflow, then drain in order
        busy_force = 1'b1;
        for (int i = 1; i <= 4; i++) press(DATA_W'(i), 1);
        check_eq("fill_full", full, 1);
        check_eq("fill_count", fifo_count, 4);
        check_eq("fill_overflow_clear", overflow, 0);
        press(8'h05, 0);
        check_eq("ovf_overflow", overflow, 1);
        check_eq("ovf_count", fifo_count, 4);
        busy_force = 1'b0;
        wait_drain(400);
        check_eq("ovf_sticky", overflow, 1);
        check_eq("ovf_empty_after", empty, 1);

        // ---- push and pop in the same cycle while full
        do_reset();
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) press(8'hA1 + DATA_W'(i), 1);
        check_eq("pp_full_before", full, 1);
        @(negedge clk);
        sw_data = 8'hA5;
        btn_in  = 1'b1;
        sb.push_back(8'hA5);
        repeat (PUSH_LAT) @(negedge clk);
        busy_force = 1'b0;            // pop coincides with the push pulse
        @(negedge clk);
        check_eq("pp_count", fifo_count, 4);
        check_eq("pp_overflow", overflow, 0);
        check_eq("pp_full", full, 1);
        repeat (HOLD) @(negedge clk);
        btn_in = 1'b0;
        wait_drain(400);
        check_eq("pp_empty_after", empty, 1);

        // ---- transmitter never acknowledges
        model_en   = 1'b0;
        busy_force = 1'b1;
        press(8'hC1, 1);
        press(8'hC2, 1);
        base = start_count;
        busy_force = 1'b0;
        for (int i = 0; i < 200 && start_count < base + 2; i++) @(negedge clk);
        check_eq("timeout_starts", start_count - base, 2);
        check_eq("timeout_gap", last_start_cyc - prev_start_cyc, ACK_TIMEOUT + 2);
        repeat (ACK_TIMEOUT + 10) @(negedge clk);
        model_en = 1'b1;

        // ---- reset during WAIT_DONE with two bytes queued
        frame_len  = 40;
        busy_force = 1'b1;
        press(8'hD1, 1);
        press(8'hD2, 1);
        press(8'hD3, 1);
        base = start_count;
        busy_force = 1'b0;
        for (int i = 0; i < 20 && start_count == base; i++) @(negedge clk);
        check_eq("wd_first_start", start_count - base, 1);
        repeat (3) @(negedge clk);
        check_eq("wd_queued", fifo_count, 2);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        base = start_count;
        repeat (60) @(negedge clk);
        check_eq("post_rst_no_start", start_count - base, 0);
        check_eq("post_rst_empty", empty, 1);
        frame_len = 10;
        press(8'hE7, 1);
        wait_drain(200);
        check_eq("post_rst_new_start", start_count - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_feeder
